// File: rtl/bb_ext_pkg.sv
// bb_ext_pkg: shared types and constants for the blackbone external-bus initiator
package bb_ext_pkg;
  localparam int BB_EXT_MAX_READ_LATENCY = 7;
  localparam int BB_EXT_ADDR_WIDTH = 14;
  localparam int BB_EXT_LEN_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RD_RESP} bb_ext_state_t;
  typedef struct packed {
    logic                        we;
    logic [BB_EXT_ADDR_WIDTH-1:0] addr;
    logic [BB_EXT_LEN_WIDTH-1:0]  len;
  } bb_ext_cmd_t;
endpackage

// File: rtl/bb_ext_if.sv
// bb_ext_if: command, write, response and external-bus signals of the initiator
interface bb_ext_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_we_i;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [LEN_WIDTH-1:0]    cmd_len_i;
  logic                    wr_valid_i;
  logic                    wr_ready_o;
  logic [DATA_WIDTH-1:0]   wr_data_i;
  logic [DATA_WIDTH/8-1:0] wr_be_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_data_o;
  logic                    rsp_last_o;
  logic                    busy_o;
  logic [ADDR_WIDTH-1:0]   bb_ext_addr_o;
  logic [DATA_WIDTH-1:0]   bb_ext_din_o;
  logic                    bb_ext_en_o;
  logic [DATA_WIDTH/8-1:0] bb_ext_we_o;
  logic [DATA_WIDTH-1:0]   bb_ext_dout_i;
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i, wr_valid_i, wr_data_i, wr_be_i,
           rsp_ready_i, bb_ext_dout_i,
    output cmd_ready_o, wr_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, busy_o,
           bb_ext_addr_o, bb_ext_din_o, bb_ext_en_o, bb_ext_we_o
  );
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i, wr_valid_i, wr_data_i, wr_be_i,
           rsp_ready_i, bb_ext_dout_i,
    input  cmd_ready_o, wr_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, busy_o,
           bb_ext_addr_o, bb_ext_din_o, bb_ext_en_o, bb_ext_we_o
  );
endinterface

// File: rtl/bb_ext_rd_delay.sv
// bb_ext_rd_delay: counts the slave read latency and strobes when dout is valid
module bb_ext_rd_delay import bb_ext_pkg::*; #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic done
);
  localparam int W = $clog2(BB_EXT_MAX_READ_LATENCY + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start) cnt <= W'(LATENCY - 1);
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
  assign done = run && cnt == '0;
endmodule

// File: rtl/bb_ext_initiator.sv
// bb_ext_initiator: turns read/write burst commands into word-addressed external-bus cycles
module bb_ext_initiator import bb_ext_pkg::*; #(
  parameter int ADDR_WIDTH   = BB_EXT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = 16,
  parameter int LEN_WIDTH    = BB_EXT_LEN_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input logic      clk,
  input logic      rst_n,
  bb_ext_if.master bus
);
  bb_ext_state_t state, state_d;
  bb_ext_cmd_t cur;
  logic cmd_fire, wr_fire, rsp_fire, rd_go, last, cap;
  logic [ADDR_WIDTH-1:0] addr_d;
  assign bus.cmd_ready_o = rst_n && state == IDLE;
  assign bus.wr_ready_o  = state == WR_BEAT;
  assign bus.rsp_valid_o = state == RD_RESP;
  assign bus.rsp_last_o  = bus.rsp_valid_o && last;
  assign bus.busy_o      = state != IDLE;
  assign last     = cur.len == '0;
  assign cmd_fire = bus.cmd_valid_i && bus.cmd_ready_o;
  assign wr_fire  = bus.wr_valid_i && bus.wr_ready_o;
  assign rsp_fire = bus.rsp_valid_o && bus.rsp_ready_i;
  // a read is issued straight off the command, or off the previous beat's handshake
  assign rd_go    = (cmd_fire && !bus.cmd_we_i) || (rsp_fire && !last);
  assign addr_d   = cmd_fire ? bus.cmd_addr_i : rsp_fire ? cur.addr + 1'b1 : cur.addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = !cmd_fire ? IDLE : bus.cmd_we_i ? WR_BEAT : RD_ISSUE;
      WR_BEAT:  state_d = wr_fire && last ? IDLE : WR_BEAT;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = cap ? RD_RESP : RD_WAIT;
      RD_RESP:  state_d = !rsp_fire ? RD_RESP : last ? IDLE : RD_ISSUE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur               <= '0;
      bus.bb_ext_en_o   <= 1'b0;
      bus.bb_ext_we_o   <= '0;
      bus.bb_ext_din_o  <= '0;
      bus.bb_ext_addr_o <= '0;
      bus.rsp_data_o    <= '0;
    end else begin
      if (cmd_fire) cur <= '{we: bus.cmd_we_i, addr: bus.cmd_addr_i, len: bus.cmd_len_i};
      else if (wr_fire || rsp_fire) begin
        cur.addr <= cur.addr + 1'b1;
        cur.len  <= cur.len - 1'b1;
      end
      bus.bb_ext_en_o  <= rd_go || (wr_fire && |bus.wr_be_i);
      bus.bb_ext_we_o  <= wr_fire ? bus.wr_be_i : '0;
      bus.bb_ext_din_o <= wr_fire && |bus.wr_be_i ? bus.wr_data_i : '0;
      if (rd_go || wr_fire) bus.bb_ext_addr_o <= addr_d;
      if (cap) bus.rsp_data_o <= bus.bb_ext_dout_i;
    end
  bb_ext_rd_delay #(.LATENCY(READ_LATENCY)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == RD_ISSUE),
    .run   (state == RD_WAIT),
    .done  (cap)
  );
endmodule

// File: tb/tb_bb_ext_initiator.sv
// tb_bb_ext_initiator: directed checks of bb_ext_initiator at read latency 1 and 4
module tb_bb_ext_initiator;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  bb_ext_if #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .LEN_WIDTH(8)) b1 ();
  bb_ext_if #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .LEN_WIDTH(8)) b4 ();
  bb_ext_initiator #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  bb_ext_initiator #(.READ_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  always #5 clk = ~clk;
  function automatic logic [15:0] rd_val(logic [13:0] a);
    return a == 14'h0100 ? 16'hBEEF : {2'b00, a} ^ 16'h5A00;
  endfunction
  // one-cycle-latency slave for dut1
  always @(posedge clk)
    if (b1.bb_ext_en_o && b1.bb_ext_we_o == 2'b00) b1.bb_ext_dout_i <= rd_val(b1.bb_ext_addr_o);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  logic [13:0] wa [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
  logic [15:0] wd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] sd [4] = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
  logic [1:0]  sb [4] = '{2'b11, 2'b11, 2'b00, 2'b10};
  logic [15:0] sdin [4] = '{16'hA1A1, 16'hB2B2, 16'h0000, 16'hD4D4};
  logic [13:0] sa [4] = '{14'h0010, 14'h0011, 14'h0012, 14'h0013};
  logic [13:0] ra [2] = '{14'h0201, 14'h0202};
  logic [15:0] rdat [2] = '{16'h5801, 16'h5802};
  logic        rlast [2] = '{1'b0, 1'b1};
  int en_cnt, n, stray;
  initial begin
    b1.cmd_valid_i = 0; b1.cmd_we_i = 0; b1.cmd_addr_i = 0; b1.cmd_len_i = 0;
    b1.wr_valid_i = 0; b1.wr_data_i = 0; b1.wr_be_i = 0; b1.rsp_ready_i = 0;
    b4.cmd_valid_i = 0; b4.cmd_we_i = 0; b4.cmd_addr_i = 0; b4.cmd_len_i = 0;
    b4.wr_valid_i = 0; b4.wr_data_i = 0; b4.wr_be_i = 0; b4.rsp_ready_i = 0;
    b4.bb_ext_dout_i = 0;
    rst_n = 1;
    #2 rst_n = 0;
    tick(); tick();
    chk("rst_cmd_ready", b1.cmd_ready_o, 0);
    chk("rst_en", b1.bb_ext_en_o, 0);
    chk("rst_busy", b1.busy_o, 0);
    chk("rst_rsp_valid", b1.rsp_valid_o, 0);
    chk("rst_wr_ready", b1.wr_ready_o, 0);
    chk("rst_rsp_data", b1.rsp_data_o, 0);
    chk("rst_addr", b1.bb_ext_addr_o, 0);
    rst_n = 1;
    #1;
    chk("post_rst_cmd_ready", b1.cmd_ready_o, 1);
    b1.wr_valid_i = 1; b1.wr_be_i = 2'b11; b1.wr_data_i = 16'hFFFF;
    tick();
    chk("idle_wr_ignored_en", b1.bb_ext_en_o, 0);
    chk("idle_wr_ready", b1.wr_ready_o, 0);
    b1.wr_valid_i = 0;
    b1.cmd_valid_i = 1; b1.cmd_we_i = 0; b1.cmd_addr_i = 14'h0100; b1.cmd_len_i = 0;
    tick();
    b1.cmd_valid_i = 0;
    chk("rd1_en", b1.bb_ext_en_o, 1);
    chk("rd1_addr", b1.bb_ext_addr_o, 14'h0100);
    chk("rd1_we", b1.bb_ext_we_o, 0);
    chk("rd1_busy", b1.busy_o, 1);
    tick();
    chk("rd1_en_single", b1.bb_ext_en_o, 0);
    chk("rd1_valid_early", b1.rsp_valid_o, 0);
    tick();
    chk("rd1_valid", b1.rsp_valid_o, 1);
    chk("rd1_data", b1.rsp_data_o, 16'hBEEF);
    chk("rd1_last", b1.rsp_last_o, 1);
    b1.rsp_ready_i = 1;
    tick();
    b1.rsp_ready_i = 0;
    chk("rd1_done_valid", b1.rsp_valid_o, 0);
    chk("rd1_done_cmd_ready", b1.cmd_ready_o, 1);
    b1.cmd_valid_i = 1; b1.cmd_we_i = 1; b1.cmd_addr_i = 14'h3FFE; b1.cmd_len_i = 3;
    tick();
    b1.cmd_valid_i = 0;
    chk("wr_ready", b1.wr_ready_o, 1);
    chk("wr_no_en_yet", b1.bb_ext_en_o, 0);
    b1.wr_valid_i = 1; b1.wr_be_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      b1.wr_data_i = wd[i];
      tick();
      chk("wr_en", b1.bb_ext_en_o, 1);
      chk("wr_addr", b1.bb_ext_addr_o, wa[i]);
      chk("wr_din", b1.bb_ext_din_o, wd[i]);
      chk("wr_we", b1.bb_ext_we_o, 2'b11);
    end
    b1.wr_valid_i = 0;
    chk("wr_cmd_ready", b1.cmd_ready_o, 1);
    tick();
    chk("wr_idle_en", b1.bb_ext_en_o, 0);
    chk("wr_idle_din", b1.bb_ext_din_o, 0);
    chk("wr_idle_we", b1.bb_ext_we_o, 0);
    b1.cmd_valid_i = 1; b1.cmd_we_i = 1; b1.cmd_addr_i = 14'h0010; b1.cmd_len_i = 3;
    tick();
    b1.cmd_valid_i = 0;
    b1.wr_valid_i = 1;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      b1.wr_data_i = sd[i]; b1.wr_be_i = sb[i];
      tick();
      if (b1.bb_ext_en_o) en_cnt++;
      chk("sp_we", b1.bb_ext_we_o, sb[i]);
      chk("sp_din", b1.bb_ext_din_o, sdin[i]);
      if (sb[i] != 2'b00) chk("sp_addr", b1.bb_ext_addr_o, sa[i]);
    end
    b1.wr_valid_i = 0;
    chk("sp_en_count", en_cnt, 3);
    chk("sp_cmd_ready", b1.cmd_ready_o, 1);
    chk("sp_busy", b1.busy_o, 0);
    b1.cmd_valid_i = 1; b1.cmd_we_i = 0; b1.cmd_addr_i = 14'h0200; b1.cmd_len_i = 2;
    tick();
    b1.cmd_valid_i = 0;
    chk("bp_en0", b1.bb_ext_en_o, 1);
    chk("bp_addr0", b1.bb_ext_addr_o, 14'h0200);
    tick(); tick();
    chk("bp_valid0", b1.rsp_valid_o, 1);
    chk("bp_data0", b1.rsp_data_o, 16'h5800);
    chk("bp_last0", b1.rsp_last_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", b1.rsp_valid_o, 1);
      chk("bp_hold_data", b1.rsp_data_o, 16'h5800);
      chk("bp_hold_no_en", b1.bb_ext_en_o, 0);
    end
    b1.rsp_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_en", b1.bb_ext_en_o, 1);
      chk("bp_addr", b1.bb_ext_addr_o, ra[i]);
      tick(); tick();
      chk("bp_valid", b1.rsp_valid_o, 1);
      chk("bp_data", b1.rsp_data_o, rdat[i]);
      chk("bp_last", b1.rsp_last_o, rlast[i]);
    end
    tick();
    b1.rsp_ready_i = 0;
    chk("bp_done_valid", b1.rsp_valid_o, 0);
    chk("bp_done_cmd_ready", b1.cmd_ready_o, 1);
    b1.cmd_valid_i = 1; b1.cmd_we_i = 1; b1.cmd_addr_i = 14'h0000; b1.cmd_len_i = 8'hFF;
    tick();
    b1.cmd_valid_i = 0;
    b1.wr_valid_i = 1; b1.wr_be_i = 2'b11; b1.wr_data_i = 16'h0F0F;
    en_cnt = 0;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (b1.bb_ext_en_o) en_cnt++;
      if (b1.cmd_ready_o) break;
    end
    b1.wr_valid_i = 0;
    chk("max_done", b1.cmd_ready_o, 1);
    chk("max_beats", en_cnt, 256);
    chk("max_last_addr", b1.bb_ext_addr_o, 14'h00FF);
    b4.cmd_valid_i = 1; b4.cmd_we_i = 0; b4.cmd_addr_i = 14'h0055; b4.cmd_len_i = 0;
    tick();
    b4.cmd_valid_i = 0;
    b4.bb_ext_dout_i = 16'h1111;
    chk("l4_en", b4.bb_ext_en_o, 1);
    chk("l4_addr", b4.bb_ext_addr_o, 14'h0055);
    tick(); tick(); tick();
    b4.bb_ext_dout_i = 16'hDEAD;
    chk("l4_valid_e3", b4.rsp_valid_o, 0);
    tick();
    b4.bb_ext_dout_i = 16'h4444;
    chk("l4_valid_e4", b4.rsp_valid_o, 0);
    tick();
    b4.bb_ext_dout_i = 16'hBAD0;
    chk("l4_valid", b4.rsp_valid_o, 1);
    chk("l4_data", b4.rsp_data_o, 16'h4444);
    chk("l4_last", b4.rsp_last_o, 1);
    tick();
    chk("l4_data_held", b4.rsp_data_o, 16'h4444);
    b4.rsp_ready_i = 1;
    tick();
    b4.rsp_ready_i = 0;
    chk("l4_done_valid", b4.rsp_valid_o, 0);
    chk("l4_done_cmd_ready", b4.cmd_ready_o, 1);
    b4.cmd_valid_i = 1; b4.cmd_we_i = 0; b4.cmd_addr_i = 14'h0300; b4.cmd_len_i = 3;
    tick();
    b4.cmd_valid_i = 0;
    chk("rr_en", b4.bb_ext_en_o, 1);
    tick(); tick();
    chk("rr_busy", b4.busy_o, 1);
    #2 rst_n = 0;
    #1;
    chk("rr_en_rst", b4.bb_ext_en_o, 0);
    chk("rr_busy_rst", b4.busy_o, 0);
    chk("rr_addr_rst", b4.bb_ext_addr_o, 0);
    chk("rr_valid_rst", b4.rsp_valid_o, 0);
    chk("rr_data_rst", b4.rsp_data_o, 0);
    chk("rr_cmd_ready_rst", b4.cmd_ready_o, 0);
    tick(); tick();
    #2 rst_n = 1;
    #1;
    chk("rr_cmd_ready", b4.cmd_ready_o, 1);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b4.bb_ext_en_o || b4.rsp_valid_o) stray++;
    end
    chk("rr_no_stray", stray, 0);
    chk("rr_idle", b4.busy_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
